quantization: RTL

Converts a bfloat16 value into a signed quantized integer of runtime-selectable bitwidth (2..MAX_BITWIDTH_QUANTIZED_DATA), packed in a MAX_BITWIDTH_QUANTIZED_DATA-bit container. It is the inverse of the dequantization path: value × inverse scale (bfloat16), round-half-to-even, saturate to the bitwidth range, mask unused upper bits. It is a 3-stage pipeline with valid/ready backpressure and sits between the bfloat16 compute datapath and quantized storage.

---
 rtl/quant_pkg.sv | 27 ++
 rtl/quantization_fp2int.sv | 131 +++++++++++++
 rtl/quantization.sv | 91 +++++++++
 3 files changed

// File: rtl/quant_pkg.sv
// Shared bfloat16 field constants and the stage-1 bundle
// used by the quantization pipeline.
package quant_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 7;
    localparam int BIAS     = 127;
    localparam int EXP_ZERO = 0;
    localparam int EXP_ALL1 = 255;
    localparam int SIG_W    = 16;
    localparam int XEXP_W   = EXP_W + 2;
    localparam int BW_W     = 8;
    // integer value = sig16 * 2^(exp - FRAC_SHIFT)
    localparam int FRAC_SHIFT = BIAS + 2 * MAN_W;

    typedef struct packed {
        logic              sign;
        logic [XEXP_W-1:0] exp;
        logic [SIG_W-1:0]  sig16;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
        logic [BW_W-1:0]   bitwidth;
    } stage1_t;

endpackage

// File: rtl/quantization_fp2int.sv
// Stages 2-3: bfloat16 product to integer with round-half-even,
// then clamp to the beat's bitwidth and pack.
module fp2int_bfloat16
    import quant_pkg::*;
#(
    parameter int MAX = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           advance,
    input  logic           s1_valid,
    input  stage1_t        s1,
    output logic           out_valid,
    output logic [MAX-1:0] out_data,
    output logic           out_sat
);

    localparam int IW  = MAX + SIG_W + 1;
    localparam int IW1 = IW + 1;
    localparam int W1  = MAX + 1;

    int              sh;
    logic            big;
    logic            guard_b;
    logic            sticky;
    logic            rnd_up;
    logic [2*SIG_W:0] rsh;
    logic [IW-1:0]   int_w;
    logic [IW:0]     int_r;
    logic [MAX:0]    mag_d;
    logic            ovf_d;

    always_comb begin
        sh      = int'($signed(s1.exp)) - FRAC_SHIFT;
        big     = 1'b0;
        guard_b = 1'b0;
        sticky  = 1'b0;
        rsh     = '0;
        int_w   = '0;
        if (sh >= 0) begin
            if (sh > MAX)
                big = 1'b1;
            else
                int_w = IW'(s1.sig16) << sh;
        end else if (sh >= -(SIG_W + 1)) begin
            rsh     = {s1.sig16, {(SIG_W + 1){1'b0}}} >> (-sh);
            int_w   = IW'(rsh[2*SIG_W:SIG_W+1]);
            guard_b = rsh[SIG_W];
            sticky  = |rsh[SIG_W-1:0];
        end else begin
            sticky = |s1.sig16;
        end
        rnd_up = guard_b & (sticky | int_w[0]);
        int_r  = {1'b0, int_w} + IW1'(rnd_up);
        mag_d  = s1.is_zero ? '0 : int_r[MAX:0];
        ovf_d  = s1.is_inf
               | (!s1.is_zero & (big | (|int_r[IW:MAX])));
    end

    logic            s2_valid;
    logic            s2_sign;
    logic [MAX:0]    s2_mag;
    logic            s2_ovf;
    logic            s2_nan;
    logic [BW_W-1:0] s2_bw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_ovf   <= 1'b0;
            s2_nan   <= 1'b0;
            s2_bw    <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1.sign;
            s2_mag   <= mag_d;
            s2_ovf   <= ovf_d;
            s2_nan   <= s1.is_nan;
            s2_bw    <= s1.bitwidth;
        end
    end

    logic [MAX-1:0] lim;
    logic [MAX-1:0] mask;
    logic [MAX-1:0] res;
    logic [MAX-1:0] data_d;
    logic           sat_d;

    always_comb begin
        lim   = MAX'(1) << (s2_bw - BW_W'(1));
        mask  = {MAX{1'b1}} >> (BW_W'(MAX) - s2_bw);
        res   = '0;
        sat_d = 1'b0;
        if (s2_nan) begin
            sat_d = 1'b1;
        end else if (!s2_sign) begin
            if (s2_ovf || s2_mag >= W1'(lim)) begin
                res   = lim - MAX'(1);
                sat_d = 1'b1;
            end else begin
                res = s2_mag[MAX-1:0];
            end
        end else begin
            if (s2_ovf || s2_mag > W1'(lim)) begin
                res   = MAX'(0) - lim;
                sat_d = 1'b1;
            end else begin
                res = MAX'(0) - s2_mag[MAX-1:0];
            end
        end
        data_d = res & mask;
    end

    // output regs only load real beats so they hold through stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= data_d;
                out_sat  <= sat_d;
            end
        end
    end

endmodule

// File: rtl/quantization.sv
// bfloat16 -> signed quantized integer, 3-stage pipeline with
// a global valid/ready stall.
module quantization
    import quant_pkg::*;
#(
    parameter int MAX_BITWIDTH_QUANTIZED_DATA = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic [15:0] in_data,
    input  logic [15:0] scale_inv_fp,
    input  logic [$clog2(MAX_BITWIDTH_QUANTIZED_DATA):0] bitwidth_q,
    output logic out_valid,
    input  logic out_ready,
    output logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0] out_data,
    output logic out_sat
);

    localparam int MAX = MAX_BITWIDTH_QUANTIZED_DATA;
    localparam int BQW = $clog2(MAX) + 1;

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    logic [EXP_W-1:0] a_exp;
    logic [EXP_W-1:0] b_exp;
    logic [MAN_W-1:0] a_man;
    logic [MAN_W-1:0] b_man;
    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;
    logic nan;
    logic bw_ok;
    stage1_t s1_d;

    always_comb begin
        a_exp  = in_data[EXP_W+MAN_W-1:MAN_W];
        b_exp  = scale_inv_fp[EXP_W+MAN_W-1:MAN_W];
        a_man  = in_data[MAN_W-1:0];
        b_man  = scale_inv_fp[MAN_W-1:0];
        a_zero = a_exp == EXP_W'(EXP_ZERO);
        b_zero = b_exp == EXP_W'(EXP_ZERO);
        a_inf  = a_exp == EXP_W'(EXP_ALL1) && a_man == '0;
        b_inf  = b_exp == EXP_W'(EXP_ALL1) && b_man == '0;
        a_nan  = a_exp == EXP_W'(EXP_ALL1) && a_man != '0;
        b_nan  = b_exp == EXP_W'(EXP_ALL1) && b_man != '0;
        nan    = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        bw_ok  = bitwidth_q >= BQW'(2) && bitwidth_q <= BQW'(MAX);

        s1_d          = '0;
        s1_d.sign     = in_data[15] ^ scale_inv_fp[15];
        s1_d.exp      = XEXP_W'(a_exp) + XEXP_W'(b_exp)
                      - XEXP_W'(BIAS);
        s1_d.sig16    = SIG_W'({1'b1, a_man})
                      * SIG_W'({1'b1, b_man});
        s1_d.is_nan   = nan;
        s1_d.is_inf   = (a_inf | b_inf) & !nan;
        s1_d.is_zero  = (a_zero | b_zero) & !nan;
        s1_d.bitwidth = bw_ok ? BW_W'(bitwidth_q) : BW_W'(MAX);
    end

    logic    s1_valid;
    stage1_t s1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (advance) begin
            s1_valid <= in_valid && in_ready;
            s1_q     <= s1_d;
        end
    end

    fp2int_bfloat16 #(
        .MAX (MAX)
    ) u_fp2int (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance),
        .s1_valid  (s1_valid),
        .s1        (s1_q),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

endmodule
